// File: rtl/id_ex_pkg.sv
// Shared types and constants for the decode/execute boundary.
// Payload layout and the canonical NOP live here.
package id_ex_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [XLEN-1:0] INST_NOP = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0]   inst;
    logic [XLEN-1:0]   inst_addr;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [REG_AW-1:0] rd_addr;
    logic              reg_wen;
  } id_ex_t;

  localparam int PAYLOAD_W = $bits(id_ex_t);

endpackage

// File: rtl/id_ex_pipe_reg.sv
// Width-parameterised payload register with load enable.
// Clears asynchronously; contents only matter while the owner's valid is set.
module pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex.sv
// Decode-to-execute pipeline register with a one-entry skid buffer.
// in_ready_o comes straight from the skid valid flop.
module id_ex
  import id_ex_pkg::*;
#(
  parameter logic [31:0] NOP_INST = INST_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        reg_wen_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic [4:0]  rd_addr_o,
  output logic        reg_wen_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  input  logic        flush_i
);

  id_ex_t in_pl;
  id_ex_t main_d;
  id_ex_t main_q;
  id_ex_t skid_q;

  logic main_v;
  logic skid_v;
  logic acc;
  logic fire;
  logic take_skid;
  logic main_en;
  logic skid_en;

  assign in_pl.inst      = inst_i;
  assign in_pl.inst_addr = inst_addr_i;
  assign in_pl.op1       = op1_i;
  assign in_pl.op2       = op2_i;
  assign in_pl.rd_addr   = rd_addr_i;
  assign in_pl.reg_wen   = reg_wen_i;

  assign in_ready_o = !skid_v;
  assign acc        = in_valid_i && in_ready_o;
  assign fire       = main_v && out_ready_i;
  assign take_skid  = fire && skid_v;

  // A flushed beat never lands in either entry.
  assign main_en = !flush_i &&
    (take_skid || (acc && (!main_v || out_ready_i)));
  assign skid_en = !flush_i &&
    acc && main_v && !out_ready_i;

  assign main_d = take_skid ? skid_q : in_pl;

  pipe_reg #(
    .WIDTH (PAYLOAD_W)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_reg #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_en),
    .d     (in_pl),
    .q     (skid_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush_i) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      if (main_en) begin
        main_v <= 1'b1;
      end else if (fire) begin
        main_v <= 1'b0;
      end
      if (take_skid) begin
        skid_v <= 1'b0;
      end else if (skid_en) begin
        skid_v <= 1'b1;
      end
    end
  end

  assign out_valid_o = main_v;
  assign inst_o      = main_v ? main_q.inst      : NOP_INST;
  assign inst_addr_o = main_v ? main_q.inst_addr : '0;
  assign op1_o       = main_v ? main_q.op1       : '0;
  assign op2_o       = main_v ? main_q.op2       : '0;
  assign rd_addr_o   = main_v ? main_q.rd_addr   : '0;
  assign reg_wen_o   = main_v && main_q.reg_wen;

endmodule

// File: tb/tb_id_ex.sv
// Directed and randomised checks of the id_ex skid register.
// Scoreboard queue models held beats in acceptance order.
module tb_id_ex;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [4:0]  rd_addr_i;
  logic        reg_wen_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [31:0] op1_o;
  logic [31:0] op2_o;
  logic [4:0]  rd_addr_o;
  logic        reg_wen_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        flush_i;

  int total;
  int bad;

  logic [133:0] out_pl;
  logic [133:0] in_pl;
  logic [133:0] q[$];

  assign out_pl = {inst_o, inst_addr_o, op1_o,
                   op2_o, rd_addr_o, reg_wen_o};
  assign in_pl  = {inst_i, inst_addr_i, op1_i,
                   op2_i, rd_addr_i, reg_wen_i};

  id_ex dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .rd_addr_i   (rd_addr_i),
    .reg_wen_i   (reg_wen_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o),
    .op1_o       (op1_o),
    .op2_o       (op2_o),
    .rd_addr_o   (rd_addr_o),
    .reg_wen_o   (reg_wen_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .flush_i     (flush_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [133:0] obs,
                     input logic [133:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic v,
                     input logic [31:0] inst,
                     input logic [31:0] a);
    in_valid_i  = v;
    inst_i      = inst;
    inst_addr_i = a;
    op1_i       = a + 32'd1;
    op2_i       = a + 32'd2;
    rd_addr_i   = a[6:2];
    reg_wen_i   = 1'b1;
  endtask

  logic         r0;
  logic         acc;
  logic         fire;
  logic         hv;
  logic [133:0] hold;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    out_ready_i = 1'b0;
    flush_i = 1'b0;
    put(1'b0, 32'h0, 32'h0);
    #12;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_inst", inst_o, NOP);
    chk("rst_wen", reg_wen_o, 0);
    chk("rst_rd", rd_addr_o, 0);
    chk("rst_op1", op1_o, 0);
    chk("rst_ready", in_ready_o, 1);
    rst_n = 1'b1;
    tick();

    // streaming, one beat per cycle
    out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      put(1'b1, 32'h00500093, 32'h100 + k * 4);
      tick();
      chk("str_valid", out_valid_o, 1);
      chk("str_inst", inst_o, 32'h00500093);
      chk("str_op1", op1_o, 32'h101 + k * 4);
      chk("str_ready", in_ready_o, 1);
    end
    put(1'b0, 32'h0, 32'h0);
    tick();
    chk("str_drain", out_valid_o, 0);
    chk("str_nop", inst_o, NOP);

    // stall into skid, then drain A then B
    out_ready_i = 1'b0;
    put(1'b1, 32'h00a00113, 32'h200);
    tick();
    chk("stl_a_valid", out_valid_o, 1);
    chk("stl_a_inst", inst_o, 32'h00a00113);
    put(1'b1, 32'h00b00193, 32'h204);
    tick();
    chk("stl_ready0", in_ready_o, 0);
    chk("stl_hold_a", inst_o, 32'h00a00113);
    put(1'b0, 32'h0, 32'h0);
    tick();
    chk("stl_hold_a2", op1_o, 32'h201);
    out_ready_i = 1'b1;
    tick();
    chk("stl_b_inst", inst_o, 32'h00b00193);
    chk("stl_b_op1", op1_o, 32'h205);
    chk("stl_ready1", in_ready_o, 1);
    tick();
    chk("stl_empty", out_valid_o, 0);

    // flush with both entries full and C presented
    out_ready_i = 1'b0;
    put(1'b1, 32'h00a00113, 32'h300);
    tick();
    put(1'b1, 32'h00b00193, 32'h304);
    tick();
    put(1'b1, 32'h00c00213, 32'h308);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    put(1'b0, 32'h0, 32'h0);
    chk("fl_valid", out_valid_o, 0);
    chk("fl_inst", inst_o, NOP);
    chk("fl_wen", reg_wen_o, 0);
    chk("fl_ready", in_ready_o, 1);
    out_ready_i = 1'b1;
    tick();
    tick();
    chk("fl_no_c", out_valid_o, 0);

    // flush while a beat is actually accepted
    out_ready_i = 1'b0;
    put(1'b1, 32'h00a00113, 32'h310);
    tick();
    put(1'b1, 32'h00c00213, 32'h314);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    put(1'b0, 32'h0, 32'h0);
    chk("fl2_valid", out_valid_o, 0);
    chk("fl2_ready", in_ready_o, 1);
    tick();
    chk("fl2_no_c", out_valid_o, 0);

    // asynchronous reset with both entries valid
    put(1'b1, 32'h00a00113, 32'h400);
    tick();
    put(1'b1, 32'h00b00193, 32'h404);
    tick();
    put(1'b0, 32'h0, 32'h0);
    chk("ar_pre", out_valid_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid_o, 0);
    chk("ar_inst", inst_o, NOP);
    chk("ar_wen", reg_wen_o, 0);
    chk("ar_ready", in_ready_o, 1);
    #1;
    rst_n = 1'b1;
    put(1'b1, 32'h00d00293, 32'h408);
    tick();
    chk("ar_accept", out_valid_o, 1);
    chk("ar_inst_d", inst_o, 32'h00d00293);
    put(1'b0, 32'h0, 32'h0);
    out_ready_i = 1'b1;
    tick();
    chk("ar_drain", out_valid_o, 0);

    // random traffic against the scoreboard
    for (int c = 0; c < 10000; c++) begin
      out_ready_i = 1'b0;
      #1;
      r0 = in_ready_o;
      out_ready_i = 1'b1;
      #1;
      chk("rdy_indep", in_ready_o, r0);
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 2) != 0);
      inst_i      = $urandom;
      inst_addr_i = $urandom;
      op1_i       = $urandom;
      op2_i       = $urandom;
      rd_addr_i   = 5'($urandom);
      reg_wen_i   = 1'($urandom);
      #1;
      acc  = in_valid_i && in_ready_o;
      fire = out_valid_o && out_ready_i;
      hv   = out_valid_o;
      hold = out_pl;
      tick();
      if (fire) begin
        if (q.size() == 0) begin
          chk("rnd_spurious", q.size(), 1);
        end else begin
          chk("rnd_order", hold, q[0]);
          void'(q.pop_front());
        end
      end
      if (acc) q.push_back(in_pl);
      chk("rnd_valid", out_valid_o, q.size() != 0);
      chk("rnd_ready", in_ready_o, q.size() < 2);
      if (hv && !fire) chk("rnd_stall", out_pl, hold);
      if (q.size() != 0) chk("rnd_head", out_pl, q[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex.md
ID_EX -- requirements
Module: id_ex

Interface
REQ-001 The block SHALL have parameter NOP_INST, default 32'h00000013 (addi x0,x0,0), the instruction word presented when no valid entry is held.
REQ-002 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have ports inst_i, inst_addr_i, op1_i, op2_i  input  32 each  decoded payload from decode stage.
REQ-005 The block SHALL have ports rd_addr_i  input  5 and reg_wen_i  input  1  destination register and write enable from decode.
REQ-006 The block SHALL have port in_valid_i  input  1  decode payload valid this cycle.
REQ-007 The block SHALL have port in_ready_o  output  1  stage can accept a payload this cycle.
REQ-008 The block SHALL have ports inst_o, inst_addr_o, op1_o, op2_o  output  32 each, rd_addr_o  output  5, and reg_wen_o  output  1  payload to execute.
REQ-009 The block SHALL have port out_valid_o  output  1  output payload valid.
REQ-010 The block SHALL have port out_ready_i  input  1  execute consumes the output payload this cycle.
REQ-011 The block SHALL have port flush_i  input  1  discard all held payloads (taken branch/jump from execute).

Function
REQ-012 The block SHALL hold two 134-bit entries, main (drives outputs) and skid, each with a valid bit.
REQ-013 The block SHALL drive in_ready_o = !skid_valid, taken from a register with no combinational path from out_ready_i.
REQ-014 An input beat SHALL be accepted when in_valid_i && in_ready_o.
REQ-015 The block SHALL write an accepted beat into main when main is empty or out_ready_i=1 with the skid empty; otherwise it SHALL write the beat into skid.
REQ-016 When out_valid_o && out_ready_i and the skid is valid, the block SHALL move skid to main and clear skid; an input beat accepted in that cycle is impossible because in_ready_o=0.
REQ-017 Latency: a beat accepted at edge N SHALL appear on outputs after edge N+1 when unstalled; sustained throughput SHALL be 1 beat/cycle.
REQ-018 When out_valid_o=0, the block SHALL drive inst_o=NOP_INST, reg_wen_o=0, rd_addr_o=0, and inst_addr_o/op1_o/op2_o=0.
REQ-019 While out_valid_o=1 && out_ready_i=0, all outputs SHALL remain stable.
REQ-020 On flush_i=1, main_valid and skid_valid SHALL both clear at the next edge, and a beat accepted in the same cycle SHALL be discarded.
REQ-021 flush_i SHALL have priority over all other events, and in_ready_o SHALL be 1 in the cycle after a flush.
REQ-022 Beats SHALL leave in acceptance order, with no loss and no duplication.

Reset
REQ-023 On rst_n=0, both valid bits SHALL clear asynchronously, and outputs SHALL take the REQ-018 values with in_ready_o=1.
REQ-024 Reset assertion mid-transfer SHALL drop all held beats; the first edge after release SHALL be able to accept a beat.

Structure
REQ-025 NOP_INST's default value and the 134-bit payload field widths SHALL be taken from the shared defines file (INST_NOP constant); no local magic numbers.
REQ-026 The two-entry buffer SHALL be implemented in this module; a payload register sub-module pipe_reg (width-parameterised, async active-low reset, load enable) SHALL be instantiated for main and skid.

Verification
REQ-027 The bench SHALL cover: reset released, in_valid_i=1 inst_i=32'h00500093 each cycle, out_ready_i=1 -> out_valid_o rises 1 cycle later, one beat per cycle, order preserved.
REQ-028 The bench SHALL cover: main holds beat A, out_ready_i=0, beat B sent -> B captured in skid, in_ready_o=0 next cycle, outputs stay A; out_ready_i=1 -> A then B emitted, in_ready_o=1 again.
REQ-029 The bench SHALL cover: main=A, skid=B, flush_i=1 with beat C presented -> next cycle out_valid_o=0, inst_o=32'h00000013, reg_wen_o=0, in_ready_o=1; C never emitted.
REQ-030 The bench SHALL cover: rst_n asserted low mid-cycle while both entries are valid -> outputs immediately become NOP, reg_wen_o=0, out_valid_o=0, without waiting for clk.
REQ-031 The bench SHALL cover: random in_valid_i/out_ready_i for 10k cycles against a scoreboard queue -> no loss or duplication, outputs stable under stall, in_ready_o never depends on same-cycle out_ready_i.
